// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and ASCII constants for the uart echo buffer
package uart_pkg;

  // Transform applied to each byte as it leaves the FIFO
  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_UPPER = 2'd1,
    MODE_CRLF  = 2'd2,
    MODE_SINK  = 2'd3
  } mode_e;

  // Output FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_SEND_LF = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_a     = 8'h61;
  localparam logic [7:0] ASCII_z     = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  // Byte presented downstream for a given mode; only lowercase letters change
  function automatic logic [7:0] transform_byte(input mode_e m, input logic [7:0] b);
    if (m == MODE_UPPER && b >= ASCII_a && b <= ASCII_z) begin
      return b - CASE_OFFSET;
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock byte FIFO with occupancy output
module sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Full is judged on the pre-edge state, so a same-edge pop never makes room
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB separates the full case from the empty case
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage array carries no reset; contents are meaningless while empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer advance, wrapping naturally modulo 2*DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// rtl/uart_echo_buffer.sv - byte FIFO between uart rx and tx with echo transforms
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int DROP_WHEN_FULL = 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          s_axis_tvalid,
  input  logic [7:0]                    s_axis_tdata,
  output logic                          s_axis_tready,
  output logic                          m_axis_tvalid,
  output logic [7:0]                    m_axis_tdata,
  input  logic                          m_axis_tready,
  input  logic [1:0]                    mode,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [31:0]                   rx_count
);

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       s_fire;
  logic       wr_ok;
  logic       fifo_pop;
  mode_e      mode_in;
  mode_e      mode_q;
  state_e     state;

  // In backpressure mode the port also reads not-ready while reset is held
  assign s_axis_tready = (DROP_WHEN_FULL != 0) ? 1'b1 : (aresetn && !fifo_full);
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign wr_ok         = s_fire && !fifo_full;
  assign fifo_pop      = (state == ST_IDLE) && !fifo_empty;
  assign mode_in       = mode_e'(mode);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (s_fire),
    .din   (s_axis_tdata),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Accepted-byte counter and sticky drop flag
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) rx_count <= rx_count + 32'd1;
      if (s_fire && fifo_full) overflow <= 1'b1;
    end
  end

  // Output FSM: pop in IDLE, hold byte in SEND, append LF after CR in SEND_LF
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      mode_q        <= MODE_PASS;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            mode_q <= mode_in;
            if (mode_in != MODE_SINK) begin
              m_axis_tdata  <= transform_byte(mode_in, fifo_dout);
              m_axis_tvalid <= 1'b1;
              state         <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (m_axis_tready) begin
            if (mode_q == MODE_CRLF && m_axis_tdata == ASCII_CR) begin
              m_axis_tdata <= ASCII_LF;
              state        <= ST_SEND_LF;
            end else begin
              m_axis_tvalid <= 1'b0;
              state         <= ST_IDLE;
            end
          end
        end
        ST_SEND_LF: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: begin
          m_axis_tvalid <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_echo_buffer.md
UART_ECHO_BUFFER -- requirements
Module: uart_echo_buffer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, meaning byte FIFO entries (power of two, >= 2).
REQ-002 The block SHALL have parameter DROP_WHEN_FULL, default 1, meaning 1 = never backpressure upstream and drop on full, 0 = backpressure via s_axis_tready.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: aclk, input, 1, the single clock for all logic.
REQ-004 aresetn, input, 1, asynchronous active-low reset.
REQ-005 s_axis_tvalid, input, 1, upstream byte valid (from uart_rx).
REQ-006 s_axis_tdata, input, 8, upstream byte.
REQ-007 s_axis_tready, output, 1, upstream ready.
REQ-008 m_axis_tvalid, output, 1, downstream byte valid (to uart_tx).
REQ-009 m_axis_tdata, output, 8, downstream byte.
REQ-010 m_axis_tready, input, 1, downstream ready.
REQ-011 mode, input, 2, transform select: 0 passthrough, 1 uppercase, 2 CR->CRLF expansion, 3 sink (discard).
REQ-012 fifo_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
REQ-013 overflow, output, 1, sticky flag set on any dropped byte.
REQ-014 rx_count, output, 32, count of bytes accepted into FIFO, wraps at 2^32.

Function
REQ-015 A transfer on either port SHALL occur only on a rising aclk edge with tvalid and tready both high.
REQ-016 s_axis_tready SHALL be constant 1 when DROP_WHEN_FULL=1, and !full when DROP_WHEN_FULL=0.
REQ-017 A byte SHALL be written only when the FIFO is not full at that edge; a simultaneous pop does not free space for the same-edge push.
REQ-018 An upstream transfer while full (DROP_WHEN_FULL=1) SHALL discard the byte, set overflow, and leave rx_count unchanged.
REQ-019 rx_count SHALL increment by 1 per written byte, wrapping 0xFFFF_FFFF -> 0.
REQ-020 fifo_level SHALL be +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop, range 0..FIFO_DEPTH.
REQ-021 Output FSM states SHALL be IDLE, SEND, SEND_LF.
REQ-022 IDLE: if FIFO non-empty, pop one byte, sample mode, and act: mode 3 discards it and stays IDLE; otherwise load m_axis_tdata (uppercase: 0x61..0x7A minus 0x20, other bytes unchanged) and go to SEND.
REQ-023 SEND: m_axis_tvalid=1, m_axis_tdata stable; on downstream transfer go to SEND_LF if sampled mode was 2 and byte was 0x0D, else IDLE.
REQ-024 SEND_LF: m_axis_tvalid=1, m_axis_tdata=0x0A; on downstream transfer go to IDLE.
REQ-025 A byte written at edge k SHALL, with FSM in IDLE, be popped at edge k+1 and presented with m_axis_tvalid high after edge k+1.
REQ-026 Changes to mode SHALL take effect only at the next IDLE pop; an in-progress SEND/SEND_LF completes under the sampled mode.
REQ-027 m_axis_tvalid SHALL not deassert and m_axis_tdata SHALL not change until the downstream transfer completes.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH with an extra MSB distinguishing full from empty.

Reset
REQ-029 On aresetn low, asynchronously: FSM=IDLE, FIFO empty, fifo_level=0, m_axis_tvalid=0, m_axis_tdata=0, overflow=0, rx_count=0.
REQ-030 s_axis_tready SHALL be 0 during reset when DROP_WHEN_FULL=0 and 1 when DROP_WHEN_FULL=1.
REQ-031 Reset mid-transfer SHALL abandon the pending output byte and all FIFO contents; no byte is emitted after release until a new upstream transfer.

Structure
REQ-032 Package uart_pkg SHALL hold the mode enum (MODE_PASS, MODE_UPPER, MODE_CRLF, MODE_SINK), FSM state typedef, and constants ASCII_CR=0x0D, ASCII_LF=0x0A, ASCII_a/ASCII_z, CASE_OFFSET=0x20.
REQ-033 The FIFO SHALL be a separate sub-module sync_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty/level).

Verification
REQ-034 Mode 0, send 0x41,0x62,0x0D with m_axis_tready=1 -> output 0x41,0x62,0x0D in order; rx_count=3; first tvalid one edge after first accept.
REQ-035 Mode 1, send "aZz{" (0x61,0x5A,0x7A,0x7B) -> output 0x41,0x5A,0x5A,0x7B.
REQ-036 Mode 2, send 0x0D,0x41 -> output 0x0D,0x0A,0x41; hold m_axis_tready=0 for 5 cycles during SEND_LF -> tdata stays 0x0A.
REQ-037 DROP_WHEN_FULL=1, FIFO_DEPTH=4, m_axis_tready=0, send 6 bytes -> fifo_level=4 (plus 1 in output register), overflow=1, rx_count=5; DROP_WHEN_FULL=0 same stimulus -> s_axis_tready low when full, no loss, overflow=0.
REQ-038 Mode 3, send 3 bytes -> m_axis_tvalid never high, fifo_level returns to 0, rx_count=3.
REQ-039 Assert aresetn low while m_axis_tvalid=1 and FIFO holds 3 bytes -> all outputs at reset values immediately; after release no output without new input.
